// File: rtl/temp_ctrl_pkg.sv
// temp_ctrl_pkg: shared heater-control constants (TEMP_W, DUTY_MAX) and PID FSM state enum
package temp_ctrl_pkg;
  localparam int TEMP_W = 16;
  localparam int DUTY_MAX = 1010;
  typedef enum logic [2:0] {IDLE, ERR, INTEG, MUL, SUM, OUT} state_e;
endpackage

// File: rtl/temp_pid_duty_if.sv
// temp_pid_duty_if: PID bus; master drives enable/temp_valid/temp_in/setpoint, slave returns busy/duty_valid/high_len/heater_open
interface temp_pid_duty_if;
  import temp_ctrl_pkg::*;
  logic enable;
  logic temp_valid;
  logic signed [TEMP_W-1:0] temp_in;
  logic signed [TEMP_W-1:0] setpoint;
  logic busy;
  logic duty_valid;
  logic signed [TEMP_W-1:0] high_len;
  logic heater_open;
  modport master(output enable, temp_valid, temp_in, setpoint, input busy, duty_valid, high_len, heater_open);
  modport slave(input enable, temp_valid, temp_in, setpoint, output busy, duty_valid, high_len, heater_open);
endinterface

// File: rtl/temp_pid_duty_sat_clamp.sv
// sat_clamp: combinational signed clamp of d_i (IW bits) into [LO, HI], result q_o (OW bits)
module sat_clamp #(
  parameter int IW = 18,
  parameter int OW = 17,
  parameter longint LO = -32767,
  parameter longint HI = 32767
) (
  input  logic signed [IW-1:0] d_i,
  output logic signed [OW-1:0] q_o
);
  localparam logic signed [IW-1:0] LO_C = IW'(LO);
  localparam logic signed [IW-1:0] HI_C = IW'(HI);
  localparam logic signed [OW-1:0] LO_O = OW'(LO);
  localparam logic signed [OW-1:0] HI_O = OW'(HI);
  assign q_o = d_i < LO_C ? LO_O : d_i > HI_C ? HI_O : $signed(d_i[OW-1:0]);
endmodule

// File: rtl/temp_pid_duty.sv
// temp_pid_duty: fixed-gain PID from temperature samples to clamped PWM duty; ports clk, rst_n (async low), bus (slave: enable/temp_valid/temp_in/setpoint in, busy/duty_valid/high_len/heater_open out)
module temp_pid_duty
  import temp_ctrl_pkg::*;
#(
  parameter int KP = 8,
  parameter int KI = 1,
  parameter int KD = 4,
  parameter int FRAC = 4,
  parameter int INT_LIM = 32767
) (
  input logic clk,
  input logic rst_n,
  temp_pid_duty_if.slave bus
);
  state_e state_q;
  logic signed [TEMP_W-1:0] temp_q, sp_q, high_len_q, high_len_d;
  logic signed [16:0] e_q, e_prev_q, integ_q, e_d, integ_d;
  logic signed [17:0] d_q, d_d, integ_sum;
  logic signed [31:0] p_q, i_q, dd_q;
  logic signed [33:0] u_q, sum_d, u_d;
  logic first_q, sat_hi_q, sat_lo_q, duty_valid_q, heater_open_q, hold_integ;
  assign e_d = 17'(sp_q) - 17'(temp_q);
  assign d_d = first_q ? '0 : 18'(e_d) - 18'(e_prev_q);
  assign integ_sum = 18'(integ_q) + 18'(e_q);
  assign hold_integ = (sat_hi_q && e_q > 0) || (sat_lo_q && e_q < 0);
  assign sum_d = 34'(p_q) + 34'(i_q) + 34'(dd_q);
  assign u_d = sum_d >>> FRAC;
  sat_clamp #(.IW(18), .OW(17), .LO(-INT_LIM), .HI(INT_LIM)) u_int_clamp (.d_i(integ_sum), .q_o(integ_d));
  sat_clamp #(.IW(34), .OW(TEMP_W), .LO(0), .HI(DUTY_MAX)) u_out_clamp (.d_i(u_q), .q_o(high_len_d));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      temp_q <= '0;
      sp_q <= '0;
      e_q <= '0;
      e_prev_q <= '0;
      d_q <= '0;
      integ_q <= '0;
      p_q <= '0;
      i_q <= '0;
      dd_q <= '0;
      u_q <= '0;
      high_len_q <= '0;
      first_q <= 1'b1;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      duty_valid_q <= 1'b0;
      heater_open_q <= 1'b0;
    end else begin
      heater_open_q <= bus.enable;
      duty_valid_q <= 1'b0;
      if (!bus.enable) begin
        state_q <= IDLE;
        high_len_q <= '0;
        integ_q <= '0;
        first_q <= 1'b1;
        sat_hi_q <= 1'b0;
        sat_lo_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.temp_valid) begin
            temp_q <= bus.temp_in;
            sp_q <= bus.setpoint;
            state_q <= ERR;
          end
          ERR: begin
            e_q <= e_d;
            d_q <= d_d;
            e_prev_q <= e_d;
            first_q <= 1'b0;
            state_q <= INTEG;
          end
          INTEG: begin
            if (!hold_integ) integ_q <= integ_d;
            state_q <= MUL;
          end
          MUL: begin
            p_q <= KP * 32'(e_q);
            i_q <= KI * 32'(integ_q);
            dd_q <= KD * 32'(d_q);
            state_q <= SUM;
          end
          SUM: begin
            u_q <= u_d;
            state_q <= OUT;
          end
          OUT: begin
            high_len_q <= high_len_d;
            sat_hi_q <= u_q > 34'(DUTY_MAX);
            sat_lo_q <= u_q < 0;
            duty_valid_q <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.duty_valid = duty_valid_q;
  assign bus.high_len = high_len_q;
  assign bus.heater_open = heater_open_q;
endmodule

// File: tb/tb_temp_pid_duty.sv
// tb_temp_pid_duty: scoreboard bench for temp_pid_duty with directed PID vectors
module tb_temp_pid_duty;
  typedef struct {int val; int cyc;} exp_t;
  logic clk, rst_n;
  int errors, checks, cyc;
  exp_t q[$];
  exp_t m;
  temp_pid_duty_if bus();
  temp_pid_duty dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", n, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && bus.duty_valid) begin
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_duty_valid got high_len=%0d expected no pulse", bus.high_len);
    end else begin
      m = q.pop_front();
      chk("high_len", int'(bus.high_len), m.val);
      chk("latency", cyc - m.cyc, 5);
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    bus.temp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic strobe(input int sp, input int t, input int ev, input bit expect_out);
    @(negedge clk);
    bus.setpoint = 16'(sp);
    bus.temp_in = 16'(t);
    bus.temp_valid = 1'b1;
    if (expect_out) q.push_back('{ev, cyc + 1});
    @(negedge clk);
    bus.temp_valid = 1'b0;
  endtask
  task automatic sample(input int sp, input int t, input int ev);
    strobe(sp, t, ev, 1'b1);
    repeat (7) @(negedge clk);
  endtask
  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.temp_valid = 1'b0;
    bus.temp_in = '0;
    bus.setpoint = '0;
    repeat (3) @(negedge clk);
    chk("rst_high_len", int'(bus.high_len), 0);
    chk("rst_duty_valid", int'(bus.duty_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_heater_open", int'(bus.heater_open), 0);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    sample(400, 400, 0);
    chk("heater_open_on", int'(bus.heater_open), 1);
    do_reset();
    sample(800, 400, 225);
    sample(800, 400, 250);
    do_reset();
    sample(4400, 400, 1010);
    sample(4400, 400, 1010);
    sample(400, 400, 0);
    sample(400, 400, 250);
    do_reset();
    sample(800, 400, 225);
    sample(400, 800, 0);
    do_reset();
    strobe(800, 400, 225, 1'b1);
    @(negedge clk);
    bus.temp_valid = 1'b1;
    chk("busy_during_calc", int'(bus.busy), 1);
    @(negedge clk);
    bus.temp_valid = 1'b0;
    repeat (6) @(negedge clk);
    strobe(800, 400, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("busy_in_mul", int'(bus.busy), 1);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("abort_high_len", int'(bus.high_len), 0);
    chk("abort_heater_open", int'(bus.heater_open), 0);
    chk("abort_busy", int'(bus.busy), 0);
    bus.enable = 1'b1;
    repeat (6) @(negedge clk);
    sample(800, 400, 225);
    strobe(800, 400, 0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_high_len", int'(bus.high_len), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_heater_open", int'(bus.heater_open), 0);
    chk("async_duty_valid", int'(bus.duty_valid), 0);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    sample(800, 400, 225);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
